// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, DATA_WIDTH data bits (LSB first), optional parity, one stop.
// Define UART_RX_MAJORITY_SAMPLE_EN for 2-of-3 majority sampling around the bit centre.
module uart_rx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  PARITY_ERROR,
  output logic                  FRAME_ERROR
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                  state_q, state_d;
  logic [5:0]              edge_q, edge_d;
  logic [BitCntW-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [5:0]              ps_q, ps_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic                    valid_q, valid_d;
  logic                    par_err_q, par_err_d;
  logic                    frm_err_q, frm_err_d;

  logic [5:0] half;
  logic       at_sample;
  logic       at_last;
  logic       bit_val;
  logic       start_frame;
  logic       frame_ok;

  assign half    = ps_q >> 1;
  assign at_last = (edge_q == ps_q - 6'd1);

`ifdef UART_RX_MAJORITY_SAMPLE_EN
  // hist_q[1] holds RX_IN at edge half-1, hist_q[0] at edge half when resolving at half+1.
  logic [1:0] hist_q, hist_d;

  assign hist_d    = {hist_q[0], RX_IN};
  assign at_sample = (edge_q == half + 6'd1);
  assign bit_val   = (hist_q[1] & hist_q[0]) | (hist_q[1] & RX_IN) | (hist_q[0] & RX_IN);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= hist_d;
    end
  end
`else
  assign at_sample = (edge_q == half);
  assign bit_val   = RX_IN;
`endif

  always_comb begin
    state_d     = state_q;
    edge_d      = edge_q + 6'd1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    ps_d        = ps_q;
    par_en_d    = par_en_q;
    par_typ_d   = par_typ_q;
    p_data_d    = p_data_q;
    valid_d     = 1'b0;
    par_err_d   = par_err_q;
    frm_err_d   = frm_err_q;
    start_frame = 1'b0;
    frame_ok    = 1'b0;

    unique case (state_q)
      StIdle: begin
        edge_d = 6'd0;
        bit_d  = '0;
        if (!RX_IN) begin
          start_frame = 1'b1;
        end
      end
      StStart: begin
        if (at_sample && bit_val) begin
          // High at the centre of the start bit: a glitch, not a frame.
          state_d = StIdle;
          edge_d  = 6'd0;
        end else if (at_last) begin
          state_d = StData;
          edge_d  = 6'd0;
        end
      end
      StData: begin
        if (at_sample) begin
          shift_d[bit_q] = bit_val;
        end
        if (at_last) begin
          edge_d = 6'd0;
          if (bit_q == LastBit) begin
            bit_d   = '0;
            state_d = par_en_q ? StParity : StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (at_sample && (bit_val != ((^shift_q) ^ par_typ_q))) begin
          par_err_d = 1'b1;
        end
        if (at_last) begin
          edge_d  = 6'd0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (at_sample && !bit_val) begin
          frm_err_d = 1'b1;
        end
        if (at_last) begin
          edge_d   = 6'd0;
          frame_ok = !par_err_d && !frm_err_d;
          if (frame_ok) begin
            p_data_d = shift_q;
            valid_d  = 1'b1;
          end
          // Line already low at the boundary: next start bit is underway.
          if (!RX_IN) begin
            start_frame = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        edge_d  = 6'd0;
      end
    endcase

    if (start_frame) begin
      state_d   = StStart;
      edge_d    = 6'd0;
      bit_d     = '0;
      ps_d      = prescale;
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
      par_err_d = 1'b0;
      frm_err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      edge_q    <= 6'd0;
      bit_q     <= '0;
      shift_q   <= '0;
      ps_q      <= 6'd0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      p_data_q  <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      ps_q      <= ps_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      p_data_q  <= p_data_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign P_DATA       = p_data_q;
  assign data_valid   = valid_q;
  assign PARITY_ERROR = par_err_q;
  assign FRAME_ERROR  = frm_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit, good frames queue their expected byte,
// and a monitor pops and compares on every data_valid pulse.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       PARITY_ERROR;
  logic       FRAME_ERROR;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_data = 8'h00;
  logic       prev_valid = 1'b0;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .prescale     (prescale),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .PARITY_ERROR (PARITY_ERROR),
    .FRAME_ERROR  (FRAME_ERROR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every data_valid must match the oldest queued good frame.
  always @(negedge CLK) begin
    if (RST === 1'b1 && data_valid === 1'b1) begin
      chk("valid_width", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {31'd0, data_valid}, 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("p_data", {24'd0, P_DATA}, {24'd0, e});
        chk("flags_at_valid", {30'd0, PARITY_ERROR, FRAME_ERROR}, 32'd0);
      end
    end
    prev_valid <= data_valid;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic cfg(input int ps, input logic pe, input logic pt);
    prescale = 6'(ps);
    PAR_EN   = pe;
    PAR_TYP  = pt;
  endtask

  task automatic send(input logic [7:0] d, input logic par_en, input logic par_bit,
                      input logic stop_bit, input int ps, input bit good, input bit cfg_flip);
    if (good) begin
      exp_q.push_back(d);
      last_data = d;
    end
    RX_IN = 1'b0;
    tick(ps);
    if (cfg_flip) begin
      prescale = 6'd8;
      PAR_EN   = ~PAR_EN;
      PAR_TYP  = ~PAR_TYP;
    end
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      tick(ps);
    end
    if (par_en) begin
      RX_IN = par_bit;
      tick(ps);
    end
    RX_IN = stop_bit;
    tick(ps);
    RX_IN = 1'b1;
  endtask

  task automatic drained(input string tag);
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int ps_list[3];
    ps_list = '{32, 16, 8};

    RST   = 1'b0;
    RX_IN = 1'b1;
    cfg(16, 1'b0, 1'b0);
    tick(3);
    chk("rst_p_data", {24'd0, P_DATA}, 32'd0);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_par_err", {31'd0, PARITY_ERROR}, 32'd0);
    chk("rst_frm_err", {31'd0, FRAME_ERROR}, 32'd0);
    RST = 1'b1;
    tick(4);

    // Odd parity, prescale 32.
    cfg(32, 1'b1, 1'b1);
    send(8'hBB, 1'b1, 1'b1, 1'b1, 32, 1'b1, 1'b0);
    tick(32);
    drained("odd32");
    chk("odd32_pe", {31'd0, PARITY_ERROR}, 32'd0);
    chk("odd32_fe", {31'd0, FRAME_ERROR}, 32'd0);

    foreach (ps_list[k]) begin
      cfg(ps_list[k], 1'b1, 1'b0);
      send(8'hBB, 1'b1, 1'b0, 1'b1, ps_list[k], 1'b1, 1'b0);
      tick(ps_list[k]);
      drained("even");
      chk("even_pe", {31'd0, PARITY_ERROR}, 32'd0);
    end

    foreach (ps_list[k]) begin
      cfg(ps_list[k], 1'b0, 1'b0);
      send(8'hBB, 1'b0, 1'b0, 1'b1, ps_list[k], 1'b1, 1'b0);
      tick(ps_list[k]);
      drained("nopar");
      chk("nopar_p_data", {24'd0, P_DATA}, 32'h000000BB);
    end

    // Odd parity with a different byte at prescale 8.
    cfg(8, 1'b1, 1'b1);
    send(8'h96, 1'b1, ~^8'h96, 1'b1, 8, 1'b1, 1'b0);
    tick(8);
    drained("odd8");

    // Wrong parity bit: no output, P_DATA held.
    cfg(16, 1'b1, 1'b0);
    send(8'hBB, 1'b1, 1'b1, 1'b1, 16, 1'b0, 1'b0);
    tick(16);
    drained("perr");
    chk("perr_pe", {31'd0, PARITY_ERROR}, 32'd1);
    chk("perr_fe", {31'd0, FRAME_ERROR}, 32'd0);
    chk("perr_p_data", {24'd0, P_DATA}, {24'd0, last_data});

    // Stop bit low, then a good frame clears the flags.
    cfg(16, 1'b0, 1'b0);
    send(8'h77, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b0);
    tick(16);
    drained("ferr");
    chk("ferr_fe", {31'd0, FRAME_ERROR}, 32'd1);
    chk("ferr_pe", {31'd0, PARITY_ERROR}, 32'd0);
    chk("ferr_p_data", {24'd0, P_DATA}, {24'd0, last_data});
    send(8'h5A, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b0);
    tick(16);
    drained("recover");
    chk("recover_fe", {31'd0, FRAME_ERROR}, 32'd0);
    chk("recover_pe", {31'd0, PARITY_ERROR}, 32'd0);
    chk("recover_p_data", {24'd0, P_DATA}, 32'h0000005A);

    // Back-to-back frames with no idle gap.
    cfg(8, 1'b1, 1'b1);
    send(8'h3C, 1'b1, ~^8'h3C, 1'b1, 8, 1'b1, 1'b0);
    send(8'hC3, 1'b1, ~^8'hC3, 1'b1, 8, 1'b1, 1'b0);
    tick(8);
    drained("b2b");
    chk("b2b_p_data", {24'd0, P_DATA}, 32'h000000C3);

    // Configuration changed after the start bit must not affect the frame in flight.
    cfg(16, 1'b0, 1'b0);
    send(8'hA5, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b1);
    tick(16);
    drained("cfg_latch");
    chk("cfg_latch_pe", {31'd0, PARITY_ERROR}, 32'd0);

    // Short low pulse: treated as a glitch.
    cfg(16, 1'b0, 1'b0);
    RX_IN = 1'b0;
    tick(4);
    RX_IN = 1'b1;
    tick(16 * 12);
    drained("glitch");
    chk("glitch_p_data", {24'd0, P_DATA}, {24'd0, last_data});
    chk("glitch_fe", {31'd0, FRAME_ERROR}, 32'd0);

    // Reset part-way through a frame.
    RX_IN = 1'b0;
    tick(16 * 3);
    RST = 1'b0;
    #1;
    chk("midrst_p_data", {24'd0, P_DATA}, 32'd0);
    chk("midrst_valid", {31'd0, data_valid}, 32'd0);
    chk("midrst_pe", {31'd0, PARITY_ERROR}, 32'd0);
    chk("midrst_fe", {31'd0, FRAME_ERROR}, 32'd0);
    last_data = 8'h00;
    @(negedge CLK);
    RX_IN = 1'b1;
    tick(2);
    RST = 1'b1;
    tick(16 * 12);
    drained("midrst");
    chk("midrst_after_p_data", {24'd0, P_DATA}, 32'd0);

    cfg(8, 1'b0, 1'b0);
    send(8'hE1, 1'b0, 1'b0, 1'b1, 8, 1'b1, 1'b0);
    tick(8);
    drained("final");
    chk("final_p_data", {24'd0, P_DATA}, 32'h000000E1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
